freq_div_led_seq: RTL and testbench
===================================

// Module: freq_div_led_seq
// PURPOSE
//   Parametrised successor of the 8-LED divided-clock pipeline driver.
//   Programmable divider produces a step strobe every 2*datain clocks; each step
//   advances an N_LED-wide LED pattern in one of four selectable modes.
//   Divisor and mode changes apply glitch-free, only at period/step boundaries.
//   Sits between board clock/switch inputs and the LED pins; single clock domain.
// PARAMETERS
//   N_LED  8  number of LED outputs; legal range 2..32
//   DIV_W  8  width of divisor input; internal period counter is DIV_W+1 bits
// PORTS
//   clock    in   1      system clock, rising edge
//   reset_n  in   1      async active-low reset, assert async / release sync to clock
//   enable   in   1      1 = run; 0 = freeze counter and pattern
//   datain   in   DIV_W  half-period divisor D; step period = 2*D clocks, D=0 treated as 1
//   mode     in   2      0 rotate-left, 1 rotate-right, 2 ping-pong, 3 bar-fill
//   diode    out  N_LED  LED pattern, registered
//   tick     out  1      registered 1-cycle pulse, high in the cycle diode changes
// BEHAVIOUR
//   Reset (async): cnt=0, div_q=1, mode_q=0, dir=up, diode=1 (bit0 only), tick=0.
//   All state updates below occur on rising clock edges, and only when enable=1.
//   enable=0: cnt, diode, dir, div_q and mode_q hold; tick=0.
//   Divisor capture: on any enabled edge with cnt==0, div_q <= max(datain,1).
//   Counter: terminal T = 2*div_q-1, computed in DIV_W+1 bits with no overflow.
//     cnt==T -> cnt<=0, tick<=1, step. Otherwise cnt<=cnt+1, tick<=0.
//   Latency: first step lands on the 2*D-th enabled edge after reset release.
//     datain changes mid-period take effect from the next period only.
//   Step, mode unchanged (mode==mode_q):
//     m0: diode rotates toward MSB; MSB wraps to bit0.
//     m1: diode rotates toward LSB; bit0 wraps to MSB.
//     m2: one-hot bounce. dir=up shifts left; on reaching MSB, dir<=down.
//         Shifts right until bit0, then dir<=up. End LEDs not repeated; cycle = 2*N_LED-2 steps.
//     m3: diode <= {diode[N-2:0],1'b1} until all-ones; all-ones -> 0; 0 -> 1.
//         Cycle = N_LED+1 steps.
//   Step, mode changed: mode_q<=mode, dir<=up; no advance this step.
//     diode <= start pattern: MSB-only for m1, bit0-only otherwise.
//   Mode input between steps is ignored; only its value at the step edge matters.
//   Simultaneous datain+mode change at a step edge:
//     mode restart applies on this edge; new divisor is captured on the following edge (cnt==0).
//   Illegal diode values, e.g. a multi-hot pattern in m0-m2, cannot occur.
//     Any non-one-hot diode on entry to a one-hot mode is replaced by bit0 at the next step.
//   Reset mid-period: all state returns to reset values immediately, without waiting for a clock edge.
// TESTING
//   T1 reset_n=0, D=5, m0 -> diode=8'h01, tick=0 while reset held.
//   T2 release, D=5, m0, enable=1 -> tick every 10 clks; diode 01,02,..,80,01.
//      diode[7] falls 80 clks after release.
//   T3 D 5->16 mid-period -> current step still at 10 clks; next periods 32 clks.
//   T4 m2, D=1 -> diode 01,02,..,80,40,..,02,01,02; period 14 steps, 2 clks/step.
//   T5 m3, D=1, N_LED=8 -> 01,03,07,..,FF,00,01.
//      Then switch to m1 -> next step diode=80, then 40.
//   T6 enable=0 for 7 clks mid-period -> that step delayed by exactly 7 clks.
//      D=0 -> period 2 clks. reset_n pulse mid-period -> diode=01 async, restart.

Source files
------------

// File: rtl/freq_div_led_seq_if.sv
// Control and LED signals between the board-side driver and the LED sequencer.
interface freq_div_led_seq_if #(
   parameter int N_LED = 8,
   parameter int DIV_W = 8
);
   logic             enable;
   logic [DIV_W-1:0] datain;
   logic [1:0]       mode;
   logic [N_LED-1:0] diode;
   logic             tick;

   modport master (output enable, datain, mode, input diode, tick);
   modport slave  (input enable, datain, mode, output diode, tick);
endinterface

// File: rtl/freq_div_led_seq.sv
// Programmable divider producing a step every 2*D clocks; each step advances an LED pattern.
//   mode_q | meaning
//   0      | rotate toward MSB
//   1      | rotate toward LSB
//   2      | one-hot ping-pong, dir_q selects travel direction
//   3      | bar-fill, then all-off, then restart
module freq_div_led_seq #(
   parameter int N_LED = 8,
   parameter int DIV_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   freq_div_led_seq_if.slave bus
);

   localparam logic [1:0] M_ROT_L = 2'd0;
   localparam logic [1:0] M_ROT_R = 2'd1;
   localparam logic [1:0] M_PING  = 2'd2;
   localparam logic [1:0] M_BAR   = 2'd3;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   localparam logic [N_LED-1:0] LED_LSB = {{(N_LED-1){1'b0}}, 1'b1};
   localparam logic [N_LED-1:0] LED_MSB = {1'b1, {(N_LED-1){1'b0}}};
   localparam logic [DIV_W:0]   CNT_ONE = {{DIV_W{1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [DIV_W:0]   cnt_q,   cnt_d;
   logic [DIV_W-1:0] div_q,   div_d;
   logic [1:0]       mode_q,  mode_d;
   logic             dir_q,   dir_d;
   logic [N_LED-1:0] diode_q, diode_d;
   logic             tick_q,  tick_d;

   logic [DIV_W:0]   term;
   logic             onehot;

   // div_q is never zero, so 2*div_q-1 cannot underflow in DIV_W+1 bits
   assign term   = {div_q, 1'b0} - CNT_ONE;
   assign onehot = (diode_q != '0) && ((diode_q & (diode_q - LED_LSB)) == '0);

   always_comb begin
      cnt_d   = cnt_q;
      div_d   = div_q;
      mode_d  = mode_q;
      dir_d   = dir_q;
      diode_d = diode_q;
      tick_d  = 1'b0;
      if (bus.enable) begin
         if (cnt_q == '0) begin
            div_d = (bus.datain == '0) ? DIV_ONE : bus.datain;
         end
         if (cnt_q == term) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (bus.mode != mode_q) begin
               mode_d  = bus.mode;
               dir_d   = DIR_UP;
               diode_d = (bus.mode == M_ROT_R) ? LED_MSB : LED_LSB;
            end else begin
               case (mode_q)
                  M_ROT_L: diode_d = onehot ? {diode_q[N_LED-2:0], diode_q[N_LED-1]} : LED_LSB;
                  M_ROT_R: diode_d = onehot ? {diode_q[0], diode_q[N_LED-1:1]} : LED_LSB;
                  M_PING: begin
                     if (!onehot) begin
                        diode_d = LED_LSB;
                        dir_d   = DIR_UP;
                     end else if (dir_q == DIR_UP) begin
                        if (diode_q[N_LED-1]) begin
                           diode_d = diode_q >> 1;
                           dir_d   = DIR_DN;
                        end else begin
                           diode_d = diode_q << 1;
                           if (diode_q[N_LED-2]) dir_d = DIR_DN;
                        end
                     end else begin
                        if (diode_q[0]) begin
                           diode_d = diode_q << 1;
                           dir_d   = DIR_UP;
                        end else begin
                           diode_d = diode_q >> 1;
                           if (diode_q[1]) dir_d = DIR_UP;
                        end
                     end
                  end
                  M_BAR: diode_d = (diode_q == '1) ? '0 : {diode_q[N_LED-2:0], 1'b1};
                  default: diode_d = LED_LSB;
               endcase
            end
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         div_q   <= DIV_ONE;
         mode_q  <= M_ROT_L;
         dir_q   <= DIR_UP;
         diode_q <= LED_LSB;
         tick_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         mode_q  <= mode_d;
         dir_q   <= dir_d;
         diode_q <= diode_d;
         tick_q  <= tick_d;
      end
   end

   assign bus.diode = diode_q;
   assign bus.tick  = tick_q;

endmodule

// File: tb/tb_freq_div_led_seq.sv
// Randomised and directed checks of the LED sequencer against a step-index reference model.
module tb_freq_div_led_seq;

   localparam int N  = 8;
   localparam int DW = 8;

   logic clock;
   logic reset_n;
   int   checks;
   int   errors;

   freq_div_led_seq_if #(.N_LED(N), .DIV_W(DW)) bus ();

   freq_div_led_seq #(.N_LED(N), .DIV_W(DW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: position within the current period, period length, mode and step index k
   int           m_pos, m_per, m_mode, m_k, cur_per;
   logic         exp_tick;
   logic [N-1:0] exp_diode;

   function automatic logic [N-1:0] pat(input int m, input int k);
      int          j;
      logic [63:0] v;
      case (m)
         0: v = 64'd1 << (k % N);
         1: v = 64'd1 << (N - 1 - (k % N));
         2: begin
            j = k % (2*N - 2);
            v = 64'd1 << ((j < N) ? j : (2*N - 2 - j));
         end
         default: begin
            j = k % (N + 1);
            v = (j == N) ? 64'd0 : ((64'd1 << (j + 1)) - 64'd1);
         end
      endcase
      return v[N-1:0];
   endfunction

   assign cur_per   = (m_pos == 0) ? 2 * ((bus.datain == '0) ? 1 : int'(bus.datain)) : m_per;
   assign exp_diode = pat(m_mode, m_k);

   initial begin
      m_pos = 0; m_per = 2; m_mode = 0; m_k = 0; exp_tick = 1'b0;
   end

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_pos <= 0; m_per <= 2; m_mode <= 0; m_k <= 0; exp_tick <= 1'b0;
      end else if (!bus.enable) begin
         exp_tick <= 1'b0;
      end else begin
         m_per <= cur_per;
         if (m_pos + 1 == cur_per) begin
            m_pos    <= 0;
            exp_tick <= 1'b1;
            if (int'(bus.mode) != m_mode) begin
               m_mode <= int'(bus.mode);
               m_k    <= 0;
            end else begin
               m_k <= m_k + 1;
            end
         end else begin
            m_pos    <= m_pos + 1;
            exp_tick <= 1'b0;
         end
      end
   end

   task automatic test_reset();
      repeat (3) begin
         @(negedge clock);
         checks++;
         if (bus.diode !== 8'h01 || bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold diode=%h tick=%b required diode=01 tick=0", bus.diode, bus.tick);
         end
      end
   endtask

   task automatic test_rotate();
      int first, nticks;
      first = -1; nticks = 0;
      reset_n = 1'b1;
      for (int i = 1; i <= 90; i++) begin
         @(negedge clock);
         checks++;
         if (bus.diode !== exp_diode || bus.tick !== exp_tick) begin
            errors++;
            $display("FAIL rotate cyc=%0d diode=%h tick=%b required %h %b", i, bus.diode, bus.tick, exp_diode, exp_tick);
         end
         if (bus.tick === 1'b1) begin
            nticks++;
            if (first < 0) first = i;
         end
         if (i == 80) begin
            checks++;
            if (bus.diode !== 8'h01) begin
               errors++;
               $display("FAIL rotate_wrap diode=%h required 01", bus.diode);
            end
         end
      end
      checks++;
      if (first != 10 || nticks != 9) begin
         errors++;
         $display("FAIL rotate_latency first=%0d ticks=%0d required 10 9", first, nticks);
      end
   endtask

   task automatic test_div_change();
      int found, last, gaps[2];
      int ng;
      found = 0; last = 0; ng = 0;
      // sync to a tick, change D mid-period, record the next two intervals
      for (int i = 1; i <= 200 && ng < 2; i++) begin
         @(negedge clock);
         checks++;
         if (bus.diode !== exp_diode || bus.tick !== exp_tick) begin
            errors++;
            $display("FAIL div_change cyc=%0d diode=%h tick=%b required %h %b", i, bus.diode, bus.tick, exp_diode, exp_tick);
         end
         if (bus.tick === 1'b1) begin
            if (found) begin
               gaps[ng] = i - last;
               ng++;
            end
            found = 1; last = i;
         end
         if (found && i == last + 4 && ng == 0) bus.datain = 8'd16;
      end
      checks++;
      if (ng != 2 || gaps[0] != 10 || gaps[1] != 32) begin
         errors++;
         $display("FAIL div_change_period n=%0d gap0=%0d gap1=%0d required 10 32", ng, gaps[0], gaps[1]);
      end
   endtask

   task automatic test_pingpong();
      int nticks;
      nticks = 0;
      bus.datain = 8'd1;
      bus.mode   = 2'd2;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clock);
         checks++;
         if (bus.diode !== exp_diode || bus.tick !== exp_tick) begin
            errors++;
            $display("FAIL pingpong cyc=%0d diode=%h tick=%b required %h %b", i, bus.diode, bus.tick, exp_diode, exp_tick);
         end
         if (i > 40 && bus.tick === 1'b1) nticks++;
      end
      checks++;
      if (nticks != 20) begin
         errors++;
         $display("FAIL pingpong_rate ticks=%0d required 20", nticks);
      end
   endtask

   task automatic test_barfill();
      int stage;
      stage = 0;
      bus.mode = 2'd3;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clock);
         checks++;
         if (bus.diode !== exp_diode || bus.tick !== exp_tick) begin
            errors++;
            $display("FAIL barfill cyc=%0d diode=%h tick=%b required %h %b", i, bus.diode, bus.tick, exp_diode, exp_tick);
         end
      end
      for (int i = 1; i <= 40 && stage < 3; i++) begin
         @(negedge clock);
         if (bus.tick === 1'b1) begin
            if (stage == 0) begin
               bus.mode = 2'd1;
            end else begin
               checks++;
               if (bus.diode !== ((stage == 1) ? 8'h80 : 8'h40)) begin
                  errors++;
                  $display("FAIL bar_to_rotr stage=%0d diode=%h required %h", stage, bus.diode, (stage == 1) ? 8'h80 : 8'h40);
               end
            end
            stage++;
         end
      end
      checks++;
      if (stage != 3) begin
         errors++;
         $display("FAIL bar_to_rotr_timeout stage=%0d required 3", stage);
      end
   endtask

   task automatic test_enable_gap();
      int ticks, last, gap;
      ticks = 0; last = 0; gap = -1;
      bus.datain = 8'd5;
      bus.mode   = 2'd0;
      for (int i = 1; i <= 200 && gap < 0; i++) begin
         @(negedge clock);
         checks++;
         if (bus.diode !== exp_diode || bus.tick !== exp_tick) begin
            errors++;
            $display("FAIL enable_gap cyc=%0d diode=%h tick=%b required %h %b", i, bus.diode, bus.tick, exp_diode, exp_tick);
         end
         if (bus.tick === 1'b1) begin
            if (ticks == 3) gap = i - last;
            ticks++; last = i;
         end
         if (ticks == 3 && i == last + 3)  bus.enable = 1'b0;
         if (ticks == 3 && i == last + 10) bus.enable = 1'b1;
      end
      bus.enable = 1'b1;
      checks++;
      if (gap != 17) begin
         errors++;
         $display("FAIL enable_gap_period gap=%0d required 17", gap);
      end
   endtask

   task automatic test_div_zero();
      int ticks, last, gap;
      ticks = 0; last = 0; gap = -1;
      bus.datain = 8'd0;
      for (int i = 1; i <= 100 && gap < 0; i++) begin
         @(negedge clock);
         checks++;
         if (bus.diode !== exp_diode || bus.tick !== exp_tick) begin
            errors++;
            $display("FAIL div_zero cyc=%0d diode=%h tick=%b required %h %b", i, bus.diode, bus.tick, exp_diode, exp_tick);
         end
         if (bus.tick === 1'b1) begin
            if (ticks == 2) gap = i - last;
            ticks++; last = i;
         end
      end
      checks++;
      if (gap != 2) begin
         errors++;
         $display("FAIL div_zero_period gap=%0d required 2", gap);
      end
   endtask

   task automatic test_async_reset();
      bus.datain = 8'd1;
      repeat (7) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (bus.diode !== 8'h01 || bus.tick !== 1'b0) begin
         errors++;
         $display("FAIL async_reset diode=%h tick=%b required 01 0", bus.diode, bus.tick);
      end
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clock);
         checks++;
         if (bus.diode !== exp_diode || bus.tick !== exp_tick) begin
            errors++;
            $display("FAIL async_restart cyc=%0d diode=%h tick=%b required %h %b", i, bus.diode, bus.tick, exp_diode, exp_tick);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 1; i <= 1500; i++) begin
         @(negedge clock);
         checks++;
         if (bus.diode !== exp_diode || bus.tick !== exp_tick) begin
            errors++;
            $display("FAIL random cyc=%0d diode=%h tick=%b required %h %b", i, bus.diode, bus.tick, exp_diode, exp_tick);
         end
         if ($urandom_range(0, 7) == 0)  bus.datain = 8'($urandom_range(0, 4));
         if ($urandom_range(0, 29) == 0) bus.mode   = 2'($urandom_range(0, 3));
         bus.enable = ($urandom_range(0, 9) != 0);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset_n    = 1'b0;
      bus.enable = 1'b1;
      bus.datain = 8'd5;
      bus.mode   = 2'd0;
      test_reset();
      test_rotate();
      test_div_change();
      test_pingpong();
      test_barfill();
      test_enable_gap();
      test_div_zero();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
